mem_port_arbiter: RTL and testbench

- Shares the single data-memory port (`mem`, one read/write port plus a word-only second read port) between N_REQ requesters, e.g. the RISC-V datapath load/store unit and a debug/program loader.
- Handles arbitration, per-transaction sequencing, alignment checking and response return.
- Sits between the requesters and `mem`, and drives every `mem` primary-port input.

---
 rtl/mem_port_arbiter_if.sv | 69 ++++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_pkg / mem_port_arbiter_if
//
// Shared types for the data-memory port and the bundle of signals that runs
// between the requesters, the arbiter and the primary port of the data memory.
//
// mem_dt_e : access data type (byte/half/word, signed and unsigned loads)
// errno_e  : completion status of a memory transaction
//
// Interface signals (N_REQ requesters):
//   req, req_addr, req_wd, req_we, req_dt : per-requester request fields
//   ack, rdata, rerr                      : per-transaction completion
//   m_addr, m_wd, m_we, m_dt              : drive the memory primary port
//   m_rd, m_err                           : returned by the memory primary port
//
// Modports:
//   slave  : the arbiter (consumes requests, drives the memory port)
//   master : the environment (requesters plus memory)
// -----------------------------------------------------------------------------
package mem_port_pkg;

    typedef enum logic [2:0] {
        MEM_DT_BYTE  = 3'd0,
        MEM_DT_HALF  = 3'd1,
        MEM_DT_WORD  = 3'd2,
        MEM_DT_UBYTE = 3'd4,
        MEM_DT_UHALF = 3'd5
    } mem_dt_e;

    typedef enum logic [1:0] {
        ENONE   = 2'd0,
        EALIGN  = 2'd1,
        EBOUNDS = 2'd2
    } errno_e;

endpackage

interface mem_port_arbiter_if #(parameter int N_REQ = 2);
    import mem_port_pkg::*;

    // Requester side; address and write-data slice i is [32*i+31:32*i].
    logic [N_REQ-1:0]      req;
    logic [32*N_REQ-1:0]   req_addr;
    logic [32*N_REQ-1:0]   req_wd;
    logic [N_REQ-1:0]      req_we;
    mem_dt_e [N_REQ-1:0]   req_dt;
    logic [N_REQ-1:0]      ack;
    logic [31:0]           rdata;
    errno_e                rerr;

    // Memory primary-port side.
    logic [31:0]           m_addr;
    logic [31:0]           m_wd;
    logic                  m_we;
    mem_dt_e               m_dt;
    logic [31:0]           m_rd;
    errno_e                m_err;

    modport slave (
        input  req, req_addr, req_wd, req_we, req_dt, m_rd, m_err,
        output ack, rdata, rerr, m_addr, m_wd, m_we, m_dt
    );

    modport master (
        output req, req_addr, req_wd, req_we, req_dt, m_rd, m_err,
        input  ack, rdata, rerr, m_addr, m_wd, m_we, m_dt
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the primary port of the data memory between N_REQ requesters.
// Each transaction takes three cycles: IDLE (arbitrate and latch), ACCESS
// (memory port driven, write commits at the closing edge, read data and
// status captured) and RESP (one-cycle ack to the winner). Arbitration is
// round-robin starting at index 0 after reset; the requester just served
// drops to lowest priority. Misaligned accesses never write and complete
// with EALIGN.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (requests, completions, memory port)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int N_REQ = 2
)
(
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Unknown data-type encodings are treated as misaligned so they can
    // never reach the memory as a write.
    function automatic logic is_aligned(input mem_dt_e dt, input logic [1:0] lo);
        logic ok;
        case (dt)
            MEM_DT_WORD:               ok = (lo == 2'b00);
            MEM_DT_HALF, MEM_DT_UHALF: ok = (lo[0] == 1'b0);
            MEM_DT_BYTE, MEM_DT_UBYTE: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_e             state_r;
    state_e             state_next_s;
    logic [IDX_W-1:0]   rr_r;
    logic [IDX_W-1:0]   win_r;
    logic               we_r;
    logic               aligned_r;

    logic               grant_valid_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic [IDX_W-1:0]   cand_s;
    logic [31:0]        sel_addr_s;
    logic [31:0]        sel_wd_s;
    mem_dt_e            sel_dt_s;
    logic               sel_we_s;
    logic               sel_aligned_s;
    logic [N_REQ-1:0]   ack_one_s;

    // Round-robin pick: scan offsets from high to low so the requester
    // closest to rr (smallest offset) is the last, winning assignment.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_s        = IDX_W'((int'(rr_r) + k) % N_REQ);
            grant_idx_s   = bus.req[cand_s] ? cand_s : grant_idx_s;
            grant_valid_s = grant_valid_s | bus.req[cand_s];
        end
    end

    assign sel_addr_s    = bus.req_addr[32*grant_idx_s +: 32];
    assign sel_wd_s      = bus.req_wd[32*grant_idx_s +: 32];
    assign sel_dt_s      = bus.req_dt[grant_idx_s];
    assign sel_we_s      = bus.req_we[grant_idx_s];
    assign sel_aligned_s = is_aligned(sel_dt_s, sel_addr_s[1:0]);
    assign ack_one_s     = {{(N_REQ-1){1'b0}}, 1'b1} << win_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_next_s = ST_RESP;
            ST_RESP:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Transaction datapath: latch the winner, drive the memory port from
    // those registers, capture the response and pulse ack. The m_* outputs
    // are the latched request fields themselves, so m_we is a pure register
    // that is only high for the ACCESS cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r      <= '0;
            win_r     <= '0;
            we_r      <= 1'b0;
            aligned_r <= 1'b0;
            bus.ack    <= '0;
            bus.rdata  <= 32'h0000_0000;
            bus.rerr   <= ENONE;
            bus.m_addr <= 32'h0000_0000;
            bus.m_wd   <= 32'h0000_0000;
            bus.m_we   <= 1'b0;
            bus.m_dt   <= MEM_DT_WORD;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    bus.ack <= '0;
                    if (grant_valid_s) begin
                        win_r      <= grant_idx_s;
                        we_r       <= sel_we_s;
                        aligned_r  <= sel_aligned_s;
                        bus.m_addr <= sel_addr_s;
                        bus.m_wd   <= sel_wd_s;
                        bus.m_dt   <= sel_dt_s;
                        bus.m_we   <= sel_we_s & sel_aligned_s;
                    end else begin
                        bus.m_we   <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    bus.m_we <= 1'b0;
                    bus.ack  <= ack_one_s;
                    // Writes and misaligned accesses keep the previous rdata.
                    if (!we_r && aligned_r) begin
                        bus.rdata <= bus.m_rd;
                    end else begin
                        bus.rdata <= bus.rdata;
                    end
                    bus.rerr <= aligned_r ? bus.m_err : EALIGN;
                end
                ST_RESP: begin
                    bus.m_we <= 1'b0;
                    bus.ack  <= '0;
                    rr_r     <= (win_r == IDX_W'(N_REQ - 1)) ? '0 : win_r + 1'b1;
                end
                default: begin
                    bus.m_we <= 1'b0;
                    bus.ack  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with two requesters and a small
// behavioural data memory (64 words, byte/half/word lanes with sign/zero
// extension, EBOUNDS and a marker word above address 255). Stimulus pushes
// the expected completion (requester, rdata, rerr, cycle) into a queue; a
// monitor thread pops and compares whenever an ack appears.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_port_pkg::*;

    typedef struct {
        logic [1:0]  ack;
        logic [31:0] rd;
        errno_e      err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_cmp;
    int          n_fail;
    int          cyc;
    int          we_cnt;
    exp_t        sb_q[$];

    logic [31:0] mem [64];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_val;

    mem_port_arbiter_if #(.N_REQ(2)) bus ();

    mem_port_arbiter #(.N_REQ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory read path with per-type extension.
    function automatic logic [31:0] rd_ext(input logic [31:0] w, input logic [1:0] lo, input mem_dt_e dt);
        logic [15:0] h;
        logic [7:0]  b;
        h = lo[1] ? w[31:16] : w[15:0];
        b = w[8*lo +: 8];
        case (dt)
            MEM_DT_WORD:  return w;
            MEM_DT_HALF:  return {{16{h[15]}}, h};
            MEM_DT_UHALF: return {16'h0000, h};
            MEM_DT_BYTE:  return {{24{b[7]}}, b};
            MEM_DT_UBYTE: return {24'h000000, b};
            default:      return 32'h0000_0000;
        endcase
    endfunction

    assign bus.m_rd  = (bus.m_addr < 32'd256) ? rd_ext(mem[bus.m_addr[7:2]], bus.m_addr[1:0], bus.m_dt)
                                              : 32'hbad0_bad0;
    assign bus.m_err = (bus.m_addr < 32'd256) ? ENONE : EBOUNDS;

    // Memory write port plus backdoor preload.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_val;
        end else if (bus.m_we && bus.m_addr < 32'd256) begin
            case (bus.m_dt)
                MEM_DT_WORD:               mem[bus.m_addr[7:2]] <= bus.m_wd;
                MEM_DT_HALF, MEM_DT_UHALF: mem[bus.m_addr[7:2]][16*bus.m_addr[1] +: 16] <= bus.m_wd[15:0];
                default:                   mem[bus.m_addr[7:2]][8*bus.m_addr[1:0] +: 8] <= bus.m_wd[7:0];
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor_step();
        exp_t e;
        if (rst_n === 1'b1 && bus.ack !== 2'b00) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack=%b at cycle %0d, want none", bus.ack, cyc);
            end else begin
                e = sb_q.pop_front();
                check("ack_vec",   {30'd0, bus.ack}, {30'd0, e.ack});
                check("rdata",     bus.rdata, e.rd);
                check("rerr",      {30'd0, bus.rerr}, {30'd0, e.err});
                check("ack_cycle", cyc, e.cyc);
            end
        end
    endtask

    task automatic bd_write(input logic [5:0] idx, input logic [31:0] val);
        @(posedge clk); #1;
        bd_idx = idx;
        bd_val = val;
        bd_we  = 1'b1;
        @(posedge clk); #1;
        bd_we  = 1'b0;
    endtask

    task automatic drive(input int i, input logic [31:0] addr, input logic [31:0] wd,
                         input logic we, input mem_dt_e dt);
        bus.req_addr[32*i +: 32] = addr;
        bus.req_wd[32*i +: 32]   = wd;
        bus.req_we[i]            = we;
        bus.req_dt[i]            = dt;
    endtask

    task automatic push(input int i, input logic [31:0] rd, input errno_e err, input int at);
        exp_t e;
        e.ack = 2'b01 << i;
        e.rd  = rd;
        e.err = err;
        e.cyc = at;
        sb_q.push_back(e);
    endtask

    task automatic wait_ack(input int i);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            seen = bus.ack[i];
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout: req%0d got no ack, want one within 20 cycles", i);
        end
    endtask

    task automatic run_one(input int i, input logic [31:0] addr, input logic [31:0] wd,
                           input logic we, input mem_dt_e dt,
                           input logic [31:0] exp_rd, input errno_e exp_err);
        @(posedge clk); #1;
        drive(i, addr, wd, we, dt);
        bus.req[i] = 1'b1;
        push(i, exp_rd, exp_err, cyc + 2);
        wait_ack(i);
        bus.req[i] = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Both requesters read (fields pre-driven); each drops after n acks.
    task automatic contend(input int n, input logic [31:0] rd0, input logic [31:0] rd1);
        int c0 = 0;
        int c1 = 0;
        @(posedge clk); #1;
        bus.req = 2'b11;
        for (int k = 0; k < n; k++) begin
            push(0, rd0, ENONE, cyc + 2 + 6*k);
            push(1, rd1, ENONE, cyc + 5 + 6*k);
        end
        for (int k = 0; k < 40 && (c0 < n || c1 < n); k++) begin
            @(posedge clk); #1;
            if (bus.ack[0]) c0++;
            if (bus.ack[1]) c1++;
            if (c0 >= n) bus.req[0] = 1'b0;
            if (c1 >= n) bus.req[1] = 1'b0;
        end
        check("contend_acks0", c0, n);
        check("contend_acks1", c1, n);
        bus.req = 2'b00;
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},    {30'd0, bus.ack}, 32'd0);
        check({tag, "_m_we"},   {31'd0, bus.m_we}, 32'd0);
        check({tag, "_rdata"},  bus.rdata, 32'd0);
        check({tag, "_rerr"},   {30'd0, bus.rerr}, {30'd0, ENONE});
        check({tag, "_m_addr"}, bus.m_addr, 32'd0);
        check({tag, "_m_wd"},   bus.m_wd, 32'd0);
        check({tag, "_m_dt"},   {29'd0, bus.m_dt}, {29'd0, MEM_DT_WORD});
    endtask

    initial begin
        int snap;
        n_cmp    = 0;
        n_fail   = 0;
        cyc      = 0;
        we_cnt   = 0;
        rst_n    = 1'b0;
        bd_we    = 1'b0;
        bd_idx   = 6'd0;
        bd_val   = 32'd0;
        bus.req  = 2'b00;
        bus.req_addr = 64'd0;
        bus.req_wd   = 64'd0;
        bus.req_we   = 2'b00;
        bus.req_dt[0] = MEM_DT_WORD;
        bus.req_dt[1] = MEM_DT_WORD;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                if (bus.m_we === 1'b1) we_cnt++;
                monitor_step();
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single half write into the low half of word 12.
        bd_write(6'd12, 32'h1234_5678);
        run_one(0, 32'd48, 32'h0000_dead, 1'b1, MEM_DT_HALF, 32'h0000_0000, ENONE);
        check("write_half", mem[12], 32'h1234_dead);

        // Signed and unsigned half reads of the upper half.
        bd_write(6'd12, 32'h8284_8688);
        run_one(1, 32'd50, 32'd0, 1'b0, MEM_DT_HALF,  32'hffff_8284, ENONE);
        run_one(1, 32'd50, 32'd0, 1'b0, MEM_DT_UHALF, 32'h0000_8284, ENONE);

        // Continuous contention: strict alternation starting at 0.
        bd_write(6'd12, 32'h1111_2222);
        bd_write(6'd13, 32'h3333_4444);
        drive(0, 32'd48, 32'd0, 1'b0, MEM_DT_WORD);
        drive(1, 32'd52, 32'd0, 1'b0, MEM_DT_WORD);
        contend(2, 32'h1111_2222, 32'h3333_4444);

        // Memory error status passes through for an aligned access.
        run_one(1, 32'h0000_0400, 32'd0, 1'b0, MEM_DT_WORD, 32'hbad0_bad0, EBOUNDS);

        // Misaligned writes: no m_we, word untouched, EALIGN, rdata held.
        bd_write(6'd12, 32'h1234_5678);
        snap = we_cnt;
        run_one(0, 32'd50, 32'hcafe_f00d, 1'b1, MEM_DT_WORD, 32'hbad0_bad0, EALIGN);
        check("misalign_word_we", we_cnt - snap, 32'd0);
        check("misalign_word_mem", mem[12], 32'h1234_5678);
        snap = we_cnt;
        run_one(0, 32'd49, 32'hcafe_f00d, 1'b1, MEM_DT_HALF, 32'hbad0_bad0, EALIGN);
        check("misalign_half_we", we_cnt - snap, 32'd0);
        check("misalign_half_mem", mem[12], 32'h1234_5678);

        // Reset during ACCESS of an aligned write: aborted, no ack.
        @(posedge clk); #1;
        drive(0, 32'd48, 32'hffff_ffff, 1'b1, MEM_DT_WORD);
        bus.req[0] = 1'b1;
        @(posedge clk); #1;
        check("midop_we_before", {31'd0, bus.m_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midop_we_dropped", {31'd0, bus.m_we}, 32'd0);
        bus.req[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midop");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        check("midop_mem", mem[12], 32'h1234_5678);

        // Pointer back at 0 after reset: requester 0 wins the first tie.
        drive(0, 32'd48, 32'd0, 1'b0, MEM_DT_WORD);
        drive(1, 32'd52, 32'd0, 1'b0, MEM_DT_WORD);
        contend(1, 32'h1234_5678, 32'h3333_4444);

        // Lone requester 1 granted normally.
        run_one(1, 32'd52, 32'd0, 1'b0, MEM_DT_UHALF, 32'h0000_4444, ENONE);

        // Back-to-back byte writes from requester 0 with req held.
        @(posedge clk); #1;
        drive(0, 32'd48, 32'h0000_00aa, 1'b1, MEM_DT_BYTE);
        bus.req[0] = 1'b1;
        push(0, 32'h0000_4444, ENONE, cyc + 2);
        push(0, 32'h0000_4444, ENONE, cyc + 5);
        wait_ack(0);
        drive(0, 32'd49, 32'h0000_00bb, 1'b1, MEM_DT_BYTE);
        wait_ack(0);
        bus.req[0] = 1'b0;
        repeat (3) @(posedge clk);
        check("b2b_low_half", {16'h0000, mem[12][15:0]}, 32'h0000_bbaa);
        check("b2b_word", mem[12], 32'h1234_bbaa);

        repeat (4) @(posedge clk);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
